icache_axi_rd_bridge: RTL
=========================

Name: icache_axi_rd_bridge

Overview:
Read-only AXI4 master bridge directly downstream of the instruction cache. It accepts one line-refill or uncached-word request at a time over the cache's rd_req/rd_rdy handshake and issues a single AXI4 AR transaction. It collects the R beats into a 128-bit return line and hands the line back with a one-cycle ret_valid pulse. One outstanding transaction; no write channels.

Parameters:
AXI_ID, 4'd0, constant value driven on arid
DATA_WIDTH, 32, AXI data width in bits; fixed at 32
LINE_WORD_NUM, 4, words per cache line; burst length for cached requests; line width = LINE_WORD_NUM*DATA_WIDTH = 128

Ports:
clk_g  input  1  clock
resetn  input  1  synchronous, active-low reset
rd_req  input  1  cache read request
rd_uncache  input  1  1 = uncached single-word read, 0 = cached line refill
rd_addr  input  32  request address; the cache supplies it line-aligned for cached reads
rd_rdy  output  1  bridge can accept a request
ret_valid  output  1  one-cycle pulse; ret_data is valid
ret_data  output  128  returned line; word i in bits [32i+31:32i]; an uncached word is in [127:96]
arid  output  4  AXI_ID
araddr  output  32  AR address
arlen  output  8  beats minus 1
arsize  output  3  fixed 3'b010
arburst  output  2  fixed 2'b01 (INCR)
arvalid  output  1  AR valid
arready  input  1  AR ready
rdata  input  32  R data
rresp  input  2  R response
rlast  input  1  R last beat
rvalid  input  1  R valid
rready  output  1  R ready
err  output  1  sticky error: any nonzero rresp, or a beat-count/rlast mismatch

Behaviour:
- Reset: resetn is synchronous and active-low on clock clk_g. Reset is sampled on posedge clk_g. After reset: state = IDLE, arvalid = 0, rready = 0, ret_valid = 0, ret_data = 0, beat counter = 0, err = 0.
- State machine has four states: IDLE, AR, R, DONE.
- IDLE:
  - rd_rdy = 1 (combinational, state==IDLE); it is 0 in every other state.
  - On rd_req && rd_rdy, latch rd_addr and rd_uncache, clear the beat counter, clear the line buffer, then go to AR.
  - With rd_req low, stay in IDLE.
- AR:
  - arvalid = 1. araddr = latched address. arlen = 0 if uncached, else LINE_WORD_NUM-1.
  - AR signals stay stable until arready. On arvalid && arready, go to R.
  - arvalid is driven from a register, so it first rises the cycle after acceptance. Minimum request-to-arvalid latency is 1 cycle.
- R:
  - rready = 1.
  - On each rvalid && rready:
    - line buffer <= {rdata, buffer[127:32]} (shift-in from the top);
    - beat counter increments;
    - nonzero rresp sets err.
  - Result: after 4 beats, beat 0 sits at [31:0] and beat 3 at [127:96]. After a single uncached beat, the data sits at [127:96].
  - On a handshake with rlast = 1, go to DONE.
  - If rlast arrives with beat counter != latched arlen, set err and still go to DONE.
  - If arlen+1 beats have completed without rlast, set err and keep waiting for rlast; further beats keep shifting.
  - Gaps in rvalid are tolerated with no timeout.
- DONE:
  - ret_valid = 1 for exactly one cycle; ret_data = buffer.
  - Next state is IDLE. ret_data holds its value until the next request is accepted.
- Minimum latency from request acceptance to ret_valid, with arready=1 and back-to-back rvalid: cached 1+1+4+1 = 7 cycles; uncached 4 cycles.
- Back-to-back: rd_rdy returns the cycle after DONE. A request held high across DONE is accepted in IDLE on that cycle.
- Reset mid-operation, in any state: return to IDLE next cycle, drop arvalid/rready, no ret_valid. Any in-flight AXI beats are discarded; the interconnect is reset alongside.
- rd_req asserted outside IDLE is ignored (rd_rdy = 0). The cache must hold the request until rd_rdy.
- err is cleared only by reset. It does not suppress ret_valid.

Test Plan:
- Cached refill: rd_addr 0x1FC0_0010, arready delayed 2 cycles, rdata 0x11111111/0x22222222/0x33333333/0x44444444 with rlast on beat 4 -> araddr 0x1FC0_0010, arlen 3, arburst 01, arsize 010; ret_data = 0x44444444_33333333_22222222_11111111; ret_valid high exactly 1 cycle; err 0.
- Uncached: rd_uncache 1, rd_addr 0xBFC0_0004, rdata 0xDEADBEEF with rlast -> arlen 0, araddr 0xBFC0_0004; ret_data[127:96] = 0xDEADBEEF, lower 96 bits = 0.
- rvalid gaps: cached burst with rvalid low for 3 cycles between each beat -> same ret_data as scenario 1; no extra beats captured.
- Error: beat 2 carries rresp 2'b10, and a separate burst asserts rlast on beat 2 -> err rises and stays 1; ret_valid still pulses once for each burst.
- Reset mid-R: resetn low for 1 cycle after beat 2 -> state IDLE, rd_rdy 1, arvalid/rready 0, no ret_valid; a following request completes correctly.
- Back-to-back: rd_req held high across two cached requests -> second AR issued 2 cycles after the first ret_valid; both lines correct.

Source files
------------

// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the icache bridge and the
// memory interconnect.
interface icache_axi_rd_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Read-only AXI4 master for the instruction cache: one AR burst per request,
// R beats shifted into a 128-bit line returned with a one-cycle ret_valid.
module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID        = 4'd0,
  parameter int         DATA_WIDTH    = 32,
  parameter int         LINE_WORD_NUM = 4
) (
  input  logic                                clk_g,
  input  logic                                resetn,
  input  logic                                rd_req,
  input  logic                                rd_uncache,
  input  logic [31:0]                         rd_addr,
  output logic                                rd_rdy,
  output logic                                ret_valid,
  output logic [LINE_WORD_NUM*DATA_WIDTH-1:0] ret_data,
  output logic                                err,
  icache_axi_rd_bridge_if.master              axi
);

  localparam int LINE_W = LINE_WORD_NUM * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t              state, state_next;
  logic [31:0]         addr_q;
  logic                uncache_q;
  logic [7:0]          beat_cnt;
  logic [7:0]          len;
  logic [LINE_W-1:0]   line_q;
  logic                r_hs;

  assign len         = uncache_q ? 8'd0 : 8'(LINE_WORD_NUM - 1);
  assign r_hs        = axi.rvalid && axi.rready;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign ret_data    = line_q;

  always_ff @(posedge clk_g) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    rd_rdy      = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    ret_valid   = 1'b0;
    case (state)
      IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) state_next = AR;
      end
      AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_next = R;
      end
      R: begin
        axi.rready = 1'b1;
        if (axi.rvalid && axi.rlast) state_next = DONE;
      end
      DONE: begin
        ret_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A beat is in error if it carries a bad response, or if rlast disagrees with
  // whether this beat is the one arlen promised as the last.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      addr_q    <= '0;
      uncache_q <= 1'b0;
      beat_cnt  <= '0;
      line_q    <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && rd_req) begin
        addr_q    <= rd_addr;
        uncache_q <= rd_uncache;
        beat_cnt  <= '0;
        line_q    <= '0;
      end
      if (r_hs) begin
        line_q <= {axi.rdata, line_q[LINE_W-1:DATA_WIDTH]};
        if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
        if (axi.rresp != 2'b00 || (axi.rlast != (beat_cnt == len)))
          err <= 1'b1;
      end
    end
  end

endmodule
